// File: rtl/bus_xfer_sequencer.sv
// Register-transfer sequencer: turns MOVE/LOADI/SWAP requests into per-register R_in/R_out strobes.
// Optional build macro XFER_COUNT_EN adds a saturating transfer counter (xfer_count) with clear (count_clr).
module bus_xfer_sequencer #(
    parameter int NUM_REGS = 8,
    parameter int SEL_W    = 3,
    parameter int TEMP_REG = 7,
    parameter int DATA_W   = 32
) (
    input  logic                clk,
    input  logic                reset,
`ifdef XFER_COUNT_EN
    input  logic                count_clr,
    output logic [15:0]         xfer_count,
`endif
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_op,
    input  logic [SEL_W-1:0]    req_src,
    input  logic [SEL_W-1:0]    req_dst,
    input  logic [DATA_W-1:0]   req_imm,
    output logic [NUM_REGS-1:0] R_in_vec,
    output logic [NUM_REGS-1:0] R_out_vec,
    output logic                imm_oe,
    output logic [DATA_W-1:0]   imm_bus,
    output logic                done,
    output logic                err,
    output logic                busy
);
    localparam logic [1:0]       OP_MOVE  = 2'b00;
    localparam logic [1:0]       OP_LOADI = 2'b01;
    localparam logic [1:0]       OP_SWAP  = 2'b10;
    localparam logic [1:0]       OP_RSVD  = 2'b11;
    localparam logic [SEL_W:0]   NREGS_X  = (SEL_W+1)'(NUM_REGS);
    localparam logic [SEL_W-1:0] TEMP_SEL = SEL_W'(TEMP_REG);

    typedef enum logic [2:0] {IDLE, X1, X2, X3, FIN} state_t;

    state_t                state_q, state_d;
    logic [1:0]            op_q;
    logic [SEL_W-1:0]      src_q, dst_q;
    logic [DATA_W-1:0]     imm_q;
    logic                  fail_q;
    logic                  accept;
    logic                  src_bad, dst_bad, req_bad, req_degen;
    logic [NUM_REGS-1:0]   src_oh, dst_oh, tmp_oh;
    logic [NUM_REGS-1:0]   r_in_d, r_out_d, r_in_q, r_out_q;
    logic                  imm_oe_d, imm_oe_q, done_d, done_q, err_d, err_q;
    logic [DATA_W-1:0]     imm_bus_d, imm_bus_q;
    logic                  ready_q, busy_q;

    assign accept = req_valid && ready_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_dec
            assign src_oh[gi] = (src_q == SEL_W'(gi));
            assign dst_oh[gi] = (dst_q == SEL_W'(gi));
            assign tmp_oh[gi] = (gi == TEMP_REG);
        end
    endgenerate

    // Request screening happens on the raw inputs so the accept edge can branch straight to FIN.
    always_comb begin
        src_bad   = ({1'b0, req_src} >= NREGS_X) || (req_src == TEMP_SEL);
        dst_bad   = ({1'b0, req_dst} >= NREGS_X) || (req_dst == TEMP_SEL);
        req_bad   = (req_op == OP_RSVD) || dst_bad || ((req_op != OP_LOADI) && src_bad);
        req_degen = ((req_op == OP_MOVE) || (req_op == OP_SWAP)) && (req_src == req_dst);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= OP_MOVE;
            src_q   <= '0;
            dst_q   <= '0;
            imm_q   <= '0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q   <= req_op;
                src_q  <= req_src;
                dst_q  <= req_dst;
                imm_q  <= req_imm;
                fail_q <= req_bad;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = (req_bad || req_degen) ? FIN : X1;
            X1:   state_d = (op_q == OP_SWAP) ? X2 : FIN;
            X2:   state_d = X3;
            X3:   state_d = FIN;
            FIN:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes are decoded from the current state and registered, so they trail the state by one cycle.
    always_comb begin
        r_in_d    = '0;
        r_out_d   = '0;
        imm_oe_d  = 1'b0;
        imm_bus_d = '0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            X1: begin
                case (op_q)
                    OP_MOVE: begin
                        r_out_d = src_oh;
                        r_in_d  = dst_oh;
                    end
                    OP_LOADI: begin
                        imm_oe_d  = 1'b1;
                        imm_bus_d = imm_q;
                        r_in_d    = dst_oh;
                    end
                    OP_SWAP: begin
                        r_out_d = src_oh;
                        r_in_d  = tmp_oh;
                    end
                    default: ;
                endcase
            end
            X2: begin
                r_out_d = dst_oh;
                r_in_d  = src_oh;
            end
            X3: begin
                r_out_d = tmp_oh;
                r_in_d  = dst_oh;
            end
            FIN: begin
                done_d = 1'b1;
                err_d  = fail_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_q    <= '0;
            r_out_q   <= '0;
            imm_oe_q  <= 1'b0;
            imm_bus_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            r_in_q    <= r_in_d;
            r_out_q   <= r_out_d;
            imm_oe_q  <= imm_oe_d;
            imm_bus_q <= imm_bus_d;
            done_q    <= done_d;
            err_q     <= err_d;
            ready_q   <= (state_d == IDLE);
            busy_q    <= (state_d != IDLE);
        end
    end

`ifdef XFER_COUNT_EN
    logic [15:0] xfer_count_q;
    logic        xfer_cycle;

    assign xfer_cycle = (state_q == X1) || (state_q == X2) || (state_q == X3);

    always_ff @(posedge clk) begin
        if (reset || count_clr) begin
            xfer_count_q <= '0;
        end else if (xfer_cycle && (xfer_count_q != 16'hFFFF)) begin
            xfer_count_q <= xfer_count_q + 16'd1;
        end
    end

    assign xfer_count = xfer_count_q;
`endif

    assign R_in_vec  = r_in_q;
    assign R_out_vec = r_out_q;
    assign imm_oe    = imm_oe_q;
    assign imm_bus   = imm_bus_q;
    assign done      = done_q;
    assign err       = err_q;
    assign req_ready = ready_q;
    assign busy      = busy_q;
endmodule
